// File: rtl/bec_seq_pkg.sv
// ============================================================================
// Module   : bec_seq_pkg
// Brief    : Shared widths, limits and FSM encoding for the ladder sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bec_seq_pkg;

    localparam int KEY_W    = 163;
    localparam int LAST_BIT = 162;
    localparam int WDOG_CYC = 4095;
    localparam int WDOG_W   = 12;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/bec_seq_wdog.sv
// ============================================================================
// Module   : bec_seq_wdog
// Brief    : Reloadable up-counter raising timeout when it reaches LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bec_seq_wdog #(
    parameter int CNT_W = 12,
    parameter int LIMIT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic count_en,
    output logic timeout
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter parks at the limit so the flag stays up until the next reload.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != C_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = count_en && (cnt_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/bec_ladder_seq.sv
// ============================================================================
// Module   : bec_ladder_seq
// Brief    : Key sequencer and operand/result front end for the Montgomery
//            ladder core. Optional step watchdog: define BEC_SEQ_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bec_ladder_seq #(
    parameter int KEY_W    = bec_seq_pkg::KEY_W,
    parameter int WDOG_CYC = bec_seq_pkg::WDOG_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [KEY_W-1:0] key_in,
    input  logic [KEY_W-1:0] w1_in,
    input  logic [KEY_W-1:0] z1_in,
    input  logic [KEY_W-1:0] w2_in,
    input  logic [KEY_W-1:0] z2_in,
    output logic             bec_enable,
    output logic             bec_ki,
    output logic [KEY_W-1:0] bec_w1,
    output logic [KEY_W-1:0] bec_z1,
    output logic [KEY_W-1:0] bec_w2,
    output logic [KEY_W-1:0] bec_z2,
    input  logic             bec_next_key,
    input  logic             bec_done,
    input  logic [KEY_W-1:0] bec_wout,
    input  logic [KEY_W-1:0] bec_zout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [KEY_W-1:0] res_w,
    output logic [KEY_W-1:0] res_z,
    output logic             busy,
    output logic             err
);

    import bec_seq_pkg::*;

    seq_state_t       state_q,  state_d;
    logic [KEY_W-1:0] shreg_q,  shreg_d;
    logic [KEY_W-1:0] w1_q,     w1_d;
    logic [KEY_W-1:0] z1_q,     z1_d;
    logic [KEY_W-1:0] w2_q,     w2_d;
    logic [KEY_W-1:0] z2_q,     z2_d;
    logic [KEY_W-1:0] res_w_q,  res_w_d;
    logic [KEY_W-1:0] res_z_q,  res_z_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             load_fire;

    assign load_fire = load_valid && (state_q == IDLE);

`ifdef BEC_SEQ_WDOG_EN
    logic err_q, err_d;
    logic wd_timeout;

    bec_seq_wdog #(
        .CNT_W (WDOG_W),
        .LIMIT (WDOG_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .reload   (load_fire || ((state_q == RUN) && bec_next_key)),
        .count_en (state_q == RUN),
        .timeout  (wd_timeout)
    );
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        w1_d      = w1_q;
        z1_d      = z1_q;
        w2_d      = w2_q;
        z2_d      = z2_q;
        res_w_d   = res_w_q;
        res_z_d   = res_z_q;
        bit_cnt_d = bit_cnt_q;
`ifdef BEC_SEQ_WDOG_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    shreg_d   = key_in;
                    w1_d      = w1_in;
                    z1_d      = z1_in;
                    w2_d      = w2_in;
                    z2_d      = z2_in;
                    bit_cnt_d = '0;
`ifdef BEC_SEQ_WDOG_EN
                    err_d     = 1'b0;
`endif
                    state_d   = RUN;
                end
            end
            RUN: begin
                // done wins over a coincident next_key: the final step never shifts
                if (bec_done) begin
                    res_w_d = bec_wout;
                    res_z_d = bec_zout;
                    state_d = HOLD;
`ifdef BEC_SEQ_WDOG_EN
                    if (bit_cnt_q != CNT_W'(KEY_W - 1)) begin
                        err_d = 1'b1;
                    end
                end else if (wd_timeout) begin
                    res_w_d = '0;
                    res_z_d = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
`endif
                end else if (bec_next_key) begin
                    shreg_d = {shreg_q[KEY_W-2:0], 1'b0};
                    if (bit_cnt_q != {CNT_W{1'b1}}) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            w1_q      <= '0;
            z1_q      <= '0;
            w2_q      <= '0;
            z2_q      <= '0;
            res_w_q   <= '0;
            res_z_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            w1_q      <= w1_d;
            z1_q      <= z1_d;
            w2_q      <= w2_d;
            z2_q      <= z2_d;
            res_w_q   <= res_w_d;
            res_z_q   <= res_z_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

`ifdef BEC_SEQ_WDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign res_valid  = (state_q == HOLD);
    assign bec_enable = (state_q == RUN);
    assign bec_ki     = (state_q == RUN) && shreg_q[KEY_W-1];
    assign bec_w1     = w1_q;
    assign bec_z1     = z1_q;
    assign bec_w2     = w2_q;
    assign bec_z2     = z2_q;
    assign res_w      = res_w_q;
    assign res_z      = res_z_q;

endmodule

`default_nettype wire

// File: tb/tb_bec_ladder_seq.sv
// ============================================================================
// Module   : tb_bec_ladder_seq
// Brief    : Self-checking bench for bec_ladder_seq with a stepping ladder model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bec_ladder_seq;

    localparam int KW   = 163;
    localparam int WDOG = 4095;
    localparam logic [KW-1:0] ONE  = 1;
    localparam logic [KW-1:0] ZERO = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid, load_ready;
    logic [KW-1:0] key_in, w1_in, z1_in, w2_in, z2_in;
    logic          bec_enable, bec_ki;
    logic [KW-1:0] bec_w1, bec_z1, bec_w2, bec_z2;
    logic          bec_next_key, bec_done;
    logic [KW-1:0] bec_wout, bec_zout;
    logic          res_valid, res_ready;
    logic [KW-1:0] res_w, res_z;
    logic          busy, err;

    int            n_cmp = 0;
    int            n_bad = 0;

    logic [KW-1:0] exp_w1, exp_z1, exp_w2, exp_z2;
    logic [KW-1:0] exp_rw, exp_rz;
    logic          exp_err;

    always #5 clk = ~clk;

    bec_ladder_seq dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .key_in       (key_in),
        .w1_in        (w1_in),
        .z1_in        (z1_in),
        .w2_in        (w2_in),
        .z2_in        (z2_in),
        .bec_enable   (bec_enable),
        .bec_ki       (bec_ki),
        .bec_w1       (bec_w1),
        .bec_z1       (bec_z1),
        .bec_w2       (bec_w2),
        .bec_z2       (bec_z2),
        .bec_next_key (bec_next_key),
        .bec_done     (bec_done),
        .bec_wout     (bec_wout),
        .bec_zout     (bec_zout),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_w        (res_w),
        .res_z        (res_z),
        .busy         (busy),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [KW-1:0] rnd_word();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[KW-1:0];
    endfunction

    // Ladder model: a step lasts 8 cycles; done rides on pulse number done_at.
    // With do_done=0 the model stops pulsing and waits for the watchdog.
    task automatic run_job(input logic [KW-1:0] key, input int done_at, input bit do_done);
        int waited;
        exp_w1 = rnd_word(); exp_z1 = rnd_word();
        exp_w2 = rnd_word(); exp_z2 = rnd_word();
        key_in = key; w1_in = exp_w1; z1_in = exp_z1; w2_in = exp_w2; z2_in = exp_z2;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        key_in = rnd_word(); w1_in = rnd_word(); z1_in = rnd_word();
        w2_in = rnd_word(); z2_in = rnd_word();
        chk("busy_after_load", KW'(busy), ONE);
        chk("enable_after_load", KW'(bec_enable), ONE);
        chk("w1_loaded", bec_w1, exp_w1);
        chk("z1_loaded", bec_z1, exp_z1);
        chk("w2_loaded", bec_w2, exp_w2);
        chk("z2_loaded", bec_z2, exp_z2);
        for (int s = 0; s < done_at; s++) begin
            for (int c = 0; c < 7; c++) begin
                if (s == 50 && c == 0) begin
                    load_valid = 1'b1;
                    key_in = rnd_word(); w1_in = rnd_word(); z2_in = rnd_word();
                end
                @(negedge clk);
                load_valid = 1'b0;
            end
            chk($sformatf("ki_step%0d", s), KW'(bec_ki), KW'(key[KW-1-s]));
            if (s == 50) begin
                chk("w1_held_while_busy", bec_w1, exp_w1);
                chk("z2_held_while_busy", bec_z2, exp_z2);
            end
            bec_next_key = 1'b1;
            if (do_done && s == done_at - 1) begin
                bec_done = 1'b1;
                exp_rw = rnd_word(); exp_rz = rnd_word();
                bec_wout = exp_rw; bec_zout = exp_rz;
            end
            @(negedge clk);
            bec_next_key = 1'b0;
            bec_done = 1'b0;
            bec_wout = rnd_word(); bec_zout = rnd_word();
        end
        if (!do_done) begin
            exp_rw = ZERO; exp_rz = ZERO;
            waited = 0;
            while (res_valid !== 1'b1 && waited < WDOG + 64) begin
                @(negedge clk);
                waited++;
            end
            chk("wdog_fired_in_time", KW'(res_valid), ONE);
        end
`ifdef BEC_SEQ_WDOG_EN
        exp_err = !(do_done && done_at == KW);
`else
        exp_err = 1'b0;
`endif
        chk("res_valid_after_done", KW'(res_valid), ONE);
        chk("enable_low_after_done", KW'(bec_enable), ZERO);
        chk("ki_low_after_done", KW'(bec_ki), ZERO);
        chk("busy_low_after_done", KW'(busy), ZERO);
        chk("res_w", res_w, exp_rw);
        chk("res_z", res_z, exp_rz);
        chk("err", KW'(err), KW'(exp_err));
    endtask

    task automatic drain(input int hold);
        int bad;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_w !== exp_rw || res_z !== exp_rz ||
                bec_enable !== 1'b0 || load_ready !== 1'b0)
                bad++;
        end
        chk("hold_stable_faults", KW'(bad), ZERO);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_after_ready", KW'(load_ready), ONE);
        chk("res_valid_cleared", KW'(res_valid), ZERO);
    endtask

    initial begin
        logic [KW-1:0] k;
        rst = 1'b0;
        load_valid = 1'b0; res_ready = 1'b0;
        bec_next_key = 1'b0; bec_done = 1'b0;
        key_in = '0; w1_in = '0; z1_in = '0; w2_in = '0; z2_in = '0;
        bec_wout = '0; bec_zout = '0;
        exp_rw = '0; exp_rz = '0; exp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_load_ready", KW'(load_ready), ONE);
        chk("rst_enable", KW'(bec_enable), ZERO);
        chk("rst_res_valid", KW'(res_valid), ZERO);
        chk("rst_w1", bec_w1, ZERO);
        chk("rst_res_w", res_w, ZERO);
        rst = 1'b1;
        @(negedge clk);

        // Spurious ladder handshakes while idle
        bec_next_key = 1'b1; bec_done = 1'b1; bec_wout = rnd_word();
        repeat (3) @(negedge clk);
        bec_next_key = 1'b0; bec_done = 1'b0;
        chk("idle_ignores_next_key", KW'(load_ready), ONE);
        chk("idle_no_result", KW'(res_valid), ZERO);
        chk("idle_res_w_zero", res_w, ZERO);

        // Bit 162 and bit 0 set
        k = '0; k[KW-1] = 1'b1; k[0] = 1'b1;
        run_job(k, KW, 1'b1);
        chk("bit_cnt_final", KW'(dut.bit_cnt_q), KW'(KW - 1));
        drain(20);
        run_job(rnd_word(), KW, 1'b1);
        drain(2);
        run_job('0, KW, 1'b1);
        drain(3);
        run_job('1, KW, 1'b1);
        drain(1);
        run_job(rnd_word(), 101, 1'b1);
        drain(1);
`ifdef BEC_SEQ_WDOG_EN
        run_job(rnd_word(), 6, 1'b0);
        drain(1);
        run_job(rnd_word(), KW, 1'b1);
        drain(1);
`endif

        // Reset in the middle of a job
        key_in = rnd_word(); w1_in = rnd_word();
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_before_reset", KW'(busy), ONE);
        rst = 1'b0;
        #1;
        chk("midrst_enable", KW'(bec_enable), ZERO);
        chk("midrst_ki", KW'(bec_ki), ZERO);
        chk("midrst_load_ready", KW'(load_ready), ONE);
        chk("midrst_res_valid", KW'(res_valid), ZERO);
        chk("midrst_busy", KW'(busy), ZERO);
        chk("midrst_err", KW'(err), ZERO);
        chk("midrst_w1", bec_w1, ZERO);
        chk("midrst_z1", bec_z1, ZERO);
        chk("midrst_w2", bec_w2, ZERO);
        chk("midrst_z2", bec_z2, ZERO);
        chk("midrst_res_w", res_w, ZERO);
        chk("midrst_res_z", res_z, ZERO);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_no_result", KW'(res_valid), ZERO);
        chk("post_rst_idle", KW'(load_ready), ONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
